// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory image loader.
// Holds the state encoding, the default geometry and the IM word width.
package im_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and IM write port of the loader; master = host/memory side, slave = loader.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [WORD_W-1:0] im_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

endinterface

// File: rtl/im_word_packer.sv
// Purpose: packs MSB-first bytes into 32-bit words.
// Latency: word_valid rises the cycle after the 4th byte of a word.
// Backpressure: none; the caller only presents bytes it has accepted.
module im_word_packer
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic              word_valid_q, word_valid_d;

    always_comb begin
        shift_d      = shift_q;
        idx_d        = idx_q;
        word_valid_d = 1'b0;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_vld) begin
            shift_d      = {shift_q[WORD_W-9:0], byte_dat};
            idx_d        = idx_q + 2'd1;
            word_valid_d = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            idx_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            word_valid_q <= word_valid_d;
        end
    end

    // The shift register itself is the word; it is stable during the strobe cycle.
    assign word_valid = word_valid_q;
    assign word       = shift_q;

endmodule

// File: rtl/im_loader.sv
// Purpose: framed byte stream -> IM words at address 0.., holds CPU in reset (IM_LOADER_CHKSUM_EN adds checksum byte).
// Latency: IM write one cycle after a word's 4th byte; DONE/ERR one cycle after the deciding byte or last write.
// Backpressure: in_ready low outside header/data(/checksum) states, during start, and in the last word's write cycle.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    im_loader_if.slave  bus,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          IDX_W = ADDR_W + 1;
    localparam logic [31:0] CAP   = 32'd1 << ADDR_W;

`ifdef IM_LOADER_CHKSUM_EN
    localparam state_e TAIL_STATE = CHK;
`else
    localparam state_e TAIL_STATE = DONE;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
`ifdef IM_LOADER_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              in_rdy;
    logic              xfer;
    logic              word_vld;
    logic [WORD_W-1:0] word_dat;
    logic              last_wr;
    logic [CNT_W-1:0]  n_next;

    assign xfer    = bus.in_valid && in_rdy;
    assign n_next  = {count_q[CNT_W-9:0], bus.in_data};
    assign last_wr = word_vld && ((32'(word_cnt_q) + 32'd1) == 32'(count_q));

    im_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .byte_vld   (xfer && (state_q == DATA)),
        .byte_dat   (bus.in_data),
        .word_valid (word_vld),
        .word       (word_dat)
    );

    // The last word's write cycle refuses bytes so nothing stray reaches the packer.
    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO: in_rdy = 1'b1;
            DATA:           in_rdy = !last_wr;
`ifdef IM_LOADER_CHKSUM_EN
            CHK:            in_rdy = 1'b1;
`endif
            default:        in_rdy = 1'b0;
        endcase
        if (start) begin
            in_rdy = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        im_addr_d  = im_addr_q;
`ifdef IM_LOADER_CHKSUM_EN
        chk_d      = chk_q;
`endif
        if (start) begin
            state_d    = HDR_HI;
            count_d    = '0;
            word_cnt_d = '0;
            im_addr_d  = '0;
`ifdef IM_LOADER_CHKSUM_EN
            chk_d      = '0;
`endif
        end else begin
            // im_addr is the running word index; it steps after each strobe.
            if (word_vld) begin
                im_addr_d  = im_addr_q + ADDR_W'(1);
                word_cnt_d = word_cnt_q + IDX_W'(1);
            end
            case (state_q)
                HDR_HI: begin
                    if (xfer) begin
                        count_d = CNT_W'(bus.in_data);
                        state_d = HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        count_d = n_next;
                        if (n_next == '0) begin
                            state_d = TAIL_STATE;
                        end else if (32'(n_next) > CAP) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IM_LOADER_CHKSUM_EN
                    if (xfer) begin
                        chk_d = chk_q ^ bus.in_data;
                    end
`endif
                    if (last_wr) begin
                        state_d = TAIL_STATE;
                    end
                end
`ifdef IM_LOADER_CHKSUM_EN
                CHK: begin
                    if (xfer) begin
                        state_d = (bus.in_data == chk_q) ? DONE : ERR;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_cnt_q <= '0;
            im_addr_q  <= '0;
`ifdef IM_LOADER_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            im_addr_q  <= im_addr_d;
`ifdef IM_LOADER_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign bus.in_ready = in_rdy;
    assign bus.im_we    = word_vld;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = word_dat;

    assign busy    = is_busy(state_q);
    assign done    = (state_q == DONE);
    assign err     = (state_q == ERR);
    assign cpu_rst = (state_q != DONE);

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table of frames on a 1024-word and a 16-word loader plus restart/reset/checksum sequences.
module tb_im_loader;
    import im_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, sel, in_valid;
    logic [7:0] in_data;
    logic       cpu_rst_a, busy_a, done_a, err_a;
    logic       cpu_rst_b, busy_b, done_b, err_b;
    logic       rdy;

    im_loader_if #(.ADDR_W(10)) bus_a ();
    im_loader_if #(.ADDR_W(4))  bus_b ();

    assign bus_a.in_data  = in_data;
    assign bus_b.in_data  = in_data;
    assign bus_a.in_valid = in_valid && !sel;
    assign bus_b.in_valid = in_valid && sel;
    assign rdy            = sel ? bus_b.in_ready : bus_a.in_ready;

    im_loader #(.ADDR_W(10), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
        .cpu_rst(cpu_rst_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    im_loader #(.ADDR_W(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
        .cpu_rst(cpu_rst_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  wr_a = 0;
    int  wr_b = 0;

    // Scoreboard: every strobe must match the oldest expected write of that loader.
    always @(negedge clk) begin
        wr_t e;
        if (bus_a.im_we === 1'b1) begin
            wr_a++;
            if (qa.size() == 0) check("unexpected_we_a", 32'(bus_a.im_addr), 32'hFFFF_FFFF);
            else begin
                e = qa.pop_front();
                check("we_addr_a", 32'(bus_a.im_addr), e.addr);
                check("we_data_a", bus_a.im_wdata, e.data);
            end
        end
        if (bus_b.im_we === 1'b1) begin
            wr_b++;
            if (qb.size() == 0) check("unexpected_we_b", 32'(bus_b.im_addr), 32'hFFFF_FFFF);
            else begin
                e = qb.pop_front();
                check("we_addr_b", 32'(bus_b.im_addr), e.addr);
                check("we_data_b", bus_b.im_wdata, e.data);
            end
        end
    end

    typedef struct packed {
        logic            sel;
        logic [15:0]     n;
        logic [15:0]     nsend;
        logic            tog;
        logic [3:0][31:0] w;
        logic            exp_done;
        logic            exp_err;
        logic [31:0]     exp_addr;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i < 4) return v.w[i];
        return {8'(i), 8'hA5, ~8'(i), 8'h3C};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = rdy;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %0h saw in_ready=0, required 1", b);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic s);
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic push_exp(input logic s, input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 32'(addr);
        e.data = data;
        if (s) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] w;
        int          cap, wr0;
`ifdef IM_LOADER_CHKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        cap = v.sel ? 16 : 1024;
        wr0 = v.sel ? wr_b : wr_a;
        sel = v.sel;
        pulse_start(v.sel);
        send_byte(v.n[15:8]);
        send_byte(v.n[7:0]);
        for (int i = 0; i < int'(v.nsend); i++) begin
            w = word_of(v, i);
            push_exp(v.sel, i % cap, w);
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[8*b +: 8]);
`ifdef IM_LOADER_CHKSUM_EN
                cs = cs ^ w[8*b +: 8];
`endif
                if (v.tog) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
`ifdef IM_LOADER_CHKSUM_EN
        if (int'(v.n) <= cap) send_byte(cs);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_done"},    32'(v.sel ? done_b : done_a), 32'(v.exp_done));
        check({tag, "_err"},     32'(v.sel ? err_b : err_a), 32'(v.exp_err));
        check({tag, "_cpu_rst"}, 32'(v.sel ? cpu_rst_b : cpu_rst_a), 32'(!v.exp_done));
        check({tag, "_busy"},    32'(v.sel ? busy_b : busy_a), 32'd0);
        check({tag, "_in_ready"}, 32'(rdy), 32'd0);
        check({tag, "_im_addr"}, v.sel ? 32'(bus_b.im_addr) : 32'(bus_a.im_addr), v.exp_addr);
        check({tag, "_writes"},  32'((v.sel ? wr_b : wr_a) - wr0), 32'(v.nsend));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   wr0;

        vecs[0] = '{sel:1'b0, n:16'd2,    nsend:16'd2,  tog:1'b0,
                    w:{32'h0, 32'h0, 32'h2009FFFF, 32'h24080005}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd2};
        vecs[1] = '{sel:1'b0, n:16'd0,    nsend:16'd0,  tog:1'b0,
                    w:'0, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd0};
        vecs[2] = '{sel:1'b0, n:16'd1,    nsend:16'd1,  tog:1'b1,
                    w:{32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd1};
        vecs[3] = '{sel:1'b0, n:16'd3,    nsend:16'd3,  tog:1'b0,
                    w:{32'h0, 32'h8C010004, 32'hFFFFFFFF, 32'h00000000}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd3};
        vecs[4] = '{sel:1'b0, n:16'd1025, nsend:16'd0,  tog:1'b0,
                    w:'0, exp_done:1'b0, exp_err:1'b1, exp_addr:32'd0};
        vecs[5] = '{sel:1'b1, n:16'd17,   nsend:16'd0,  tog:1'b0,
                    w:'0, exp_done:1'b0, exp_err:1'b1, exp_addr:32'd0};
        vecs[6] = '{sel:1'b1, n:16'd16,   nsend:16'd16, tog:1'b0,
                    w:{32'h4, 32'h3, 32'h2, 32'h1}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd0};
        vecs[7] = '{sel:1'b1, n:16'd1,    nsend:16'd1,  tog:1'b1,
                    w:{32'h0, 32'h0, 32'h0, 32'h0BADF00D}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd1};

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst",  32'(cpu_rst_a), 32'd1);
        check("rst_busy",     32'(busy_a), 32'd0);
        check("rst_done",     32'(done_a), 32'd0);
        check("rst_err",      32'(err_a), 32'd0);
        check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        check("rst_im_we",    32'(bus_a.im_we), 32'd0);
        check("rst_im_addr",  32'(bus_a.im_addr), 32'd0);
        check("rst_im_wdata", bus_a.im_wdata, 32'd0);
        check("rst_cpu_rst_b", 32'(cpu_rst_b), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Empty image: DONE (or CHK) right after count_lo.
        sel = 1'b0;
        pulse_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
`ifdef IM_LOADER_CHKSUM_EN
        check("n0_in_chk_busy", 32'(busy_a), 32'd1);
        check("n0_in_chk_rdy",  32'(bus_a.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send_byte(8'h00);
        @(negedge clk);
`endif
        check("n0_done_next", 32'(done_a), 32'd1);
        check("n0_cpu_rst",   32'(cpu_rst_a), 32'd0);

        // Restart mid-word: the byte offered with start is refused and packing restarts.
        pulse_start(1'b0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        in_data = 8'hCC; in_valid = 1'b1; start_a = 1'b1;
        @(negedge clk);
        check("start_blocks_rdy", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk);
        #1;
        start_a = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("restart_busy", 32'(busy_a), 32'd1);
        check("restart_done", 32'(done_a), 32'd0);
        @(posedge clk);
        #1;
        push_exp(1'b0, 0, 32'h11223344);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef IM_LOADER_CHKSUM_EN
        send_byte(8'h44);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("restart_final_done", 32'(done_a), 32'd1);

        // Asynchronous reset after two data bytes, then a clean reload from address 0.
        pulse_start(1'b0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy",    32'(busy_a), 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst_a), 32'd1);
        check("arst_done",    32'(done_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        v = '{sel:1'b0, n:16'd1, nsend:16'd1, tog:1'b0,
              w:{32'h0, 32'h0, 32'h0, 32'h8FA80010}, exp_done:1'b1, exp_err:1'b0, exp_addr:32'd1};
        run_vec(v, "after_arst");

`ifdef IM_LOADER_CHKSUM_EN
        for (int t = 0; t < 2; t++) begin
            wr0 = wr_a;
            pulse_start(1'b0);
            push_exp(1'b0, 0, 32'h12345678);
            send_byte(8'h00); send_byte(8'h01);
            send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
            send_byte(t == 0 ? 8'h08 : 8'h09);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("chk%0d_done", t),    32'(done_a), 32'(t == 0));
            check($sformatf("chk%0d_err", t),     32'(err_a), 32'(t == 1));
            check($sformatf("chk%0d_cpu_rst", t), 32'(cpu_rst_a), 32'(t == 1));
            check($sformatf("chk%0d_writes", t),  32'(wr_a - wr0), 32'd1);
        end
`endif

        check("pending_a", 32'(qa.size()), 32'd0);
        check("pending_b", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Synthesizable writer for the multicycle MIPS instruction memory. It replaces simulation-only image loading with a byte-stream loader.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes them to consecutive IM word addresses starting at 0.
- Holds the CPU in reset during the load and releases it once the image has been written.
- Sits between the host link (UART/JTAG byte source) and the IM write port plus the CPU rst input.

Parameters:
- ADDR_W, 10, IM word-address width; capacity is 2**ADDR_W words.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins or restarts a load.
- in_data, input, 8, stream byte.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader accepts a byte this cycle.
- im_we, output, 1, IM write strobe, one cycle per word.
- im_addr, output, ADDR_W, IM word address.
- im_wdata, output, 32, IM write data.
- cpu_rst, output, 1, active-high reset driven to the CPU.
- busy, output, 1, high while a load is in progress.
- done, output, 1, load completed successfully; sticky until the next start.
- err, output, 1, load failed; sticky until the next start.

Behaviour:
- Frame format: count_hi, count_lo (N = word count, big-endian), then 4*N data bytes. Each word is sent MSB first.
- Handshake: a byte transfers when in_valid && in_ready. in_ready is 1 only in HDR_HI, HDR_LO and DATA, plus CHK when the optional feature is enabled.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cpu_rst=1; in_ready, im_we, busy, done, err = 0.
  - im_addr=0, im_wdata=0.
  - Byte and word counters are cleared.
  - Reset mid-load abandons the load; words already written stay in IM.
- States and transitions:
  - IDLE → HDR_HI on start.
  - HDR_HI → HDR_LO on a transfer; the byte is stored as count[15:8].
  - HDR_LO → on a transfer, count[7:0] is stored, then:
    - N==0 → DONE;
    - N > 2**ADDR_W → ERR;
    - otherwise → DATA.
  - DATA: each transfer shifts the byte into a 32-bit shift register; a 2-bit byte index wraps 3→0. On the 4th byte of a word:
    - the next cycle has im_we=1, im_wdata = assembled word, im_addr = word index;
    - the word index then increments.
  - DATA → DONE after the im_we of word N-1. With CHKSUM_EN, DATA goes to CHK instead.
  - DONE: cpu_rst=0 and done=1.
  - ERR: err=1, cpu_rst=1, in_ready=0.
- busy=1 in HDR_HI, HDR_LO, DATA and CHK.
- cpu_rst stays 1 in every state except DONE.
- start is honoured in every state, including mid-load:
  - state → HDR_HI, counters cleared;
  - done and err cleared, cpu_rst=1;
  - a byte presented in the same cycle as start is not accepted (in_ready=0 that cycle).
- im_addr holds its last value between strobes. Word index N == 2**ADDR_W is legal; im_addr wraps only after the final write, which is not used.
- in_ready may stay high in the cycle im_we fires, so back-to-back words at one byte per cycle are supported.
- Input bytes arriving in IDLE, DONE or ERR are not accepted.

Optional Feature:
- Macro: IM_LOADER_CHKSUM_EN.
- With it defined:
  - one trailing checksum byte follows the data, equal to the XOR of all data bytes (the header is excluded);
  - the state after the last word is CHK;
  - on transfer: match → DONE; mismatch → ERR;
  - N==0 still goes to CHK, with an expected checksum of 0x00.
- Without it: no CHK state, no checksum byte, and DATA → DONE directly.

Decomposition:
- Shared package im_loader_pkg holds:
  - the state encoding (IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR);
  - the default ADDR_W and CNT_W;
  - the word width constant 32.
- One natural sub-module: im_word_packer. It holds the byte shift register and 2-bit byte index, and emits word_valid plus the 32-bit word.
- The FSM, counters and IM/CPU outputs stay in the top.

Test Plan:
- Reset then start, stream 00 02 | 24 08 00 05 | 20 09 FF FF at one byte per cycle → im_we pulses twice: addr 0 = 0x24080005, addr 1 = 0x2009FFFF. Then done=1, cpu_rst=0, busy=0.
- Start, header 00 00 → DONE within 1 cycle of the count_lo transfer; no im_we; cpu_rst=0.
- ADDR_W=4, header 00 11 (N=17) → ERR; err=1; cpu_rst stays 1; in_ready=0; no im_we.
- Load of 1 word with in_valid toggling 1/0 each cycle → same word as the back-to-back case; exactly one im_we.
- Assert rst=0 asynchronously after 2 data bytes → cpu_rst=1 and state=IDLE immediately. A subsequent start with a full frame loads correctly from addr 0.
- With IM_LOADER_CHKSUM_EN: 00 01 | 12 34 56 78 | 08 → done=1. Repeat with checksum 09 → err=1, cpu_rst=1; the im_we for the word still occurred.
